// File: rtl/dram_pkg.sv
// Shared DRAM definitions: command encodings used by the controller FSM and
// this timing stage, the command timer state encoding, and default timings.
package dram_pkg;

    typedef enum logic [1:0] {
        CMD_ACT = 2'b00,
        CMD_COL = 2'b01,
        CMD_REF = 2'b10,
        CMD_PRE = 2'b11
    } cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_WAIT  = 2'b10,
        ST_HOLD  = 2'b11
    } state_t;

    localparam int DEF_T_RCD  = 3;
    localparam int DEF_T_CCD  = 1;
    localparam int DEF_T_RP   = 3;
    localparam int DEF_T_RFC  = 8;
    localparam int DEF_T_REFI = 780;

endpackage

// File: rtl/dram_cmd_timer_refresh.sv
// Refresh-interval timer: raises refresh_flag every T_REFI cycles and
// latches refresh_overdue if an interval expires with the flag still pending.
module dram_refresh_timer
    import dram_pkg::*;
#(
    parameter int T_REFI = DEF_T_REFI
) (
    input  logic clk,
    input  logic rst,
    input  logic ref_done,
    output logic refresh_flag,
    output logic refresh_overdue
);

    localparam logic [15:0] RELOAD = 16'(T_REFI - 1);

    logic [15:0] interval_cnt;

    // A completed REF takes priority over an expiry landing on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            interval_cnt    <= RELOAD;
            refresh_flag    <= 1'b0;
            refresh_overdue <= 1'b0;
        end else if (ref_done) begin
            interval_cnt <= RELOAD;
            refresh_flag <= 1'b0;
        end else if (interval_cnt == 16'd0) begin
            interval_cnt <= RELOAD;
            refresh_flag <= 1'b1;
            if (refresh_flag) begin
                refresh_overdue <= 1'b1;
            end
        end else begin
            interval_cnt <= interval_cnt - 16'd1;
        end
    end

endmodule

// File: rtl/dram_cmd_timer.sv
// DRAM command timing stage: issues one command strobe per request, holds the
// requester off for the command's timing parameter, then pulses cmd_ack.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | waiting for cmd_req; latches cmd on acceptance
//   ST_ISSUE | command strobe on the DRAM bus; timer loaded with T-1
//   ST_WAIT  | timer counting down; ack in the cycle it reads zero
//   ST_HOLD  | one dead cycle so the departing request is not re-accepted
module dram_cmd_timer
    import dram_pkg::*;
#(
    parameter int T_RCD  = DEF_T_RCD,
    parameter int T_CCD  = DEF_T_CCD,
    parameter int T_RP   = DEF_T_RP,
    parameter int T_RFC  = DEF_T_RFC,
    parameter int T_REFI = DEF_T_REFI
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_req,
    input  logic [1:0] cmd,
    output logic       cmd_ack,
    output logic       refresh_flag,
    output logic       refresh_overdue,
    output logic       dram_cmd_valid,
    output logic [1:0] dram_cmd,
    output logic       busy
);

    state_t     state, state_d;
    cmd_t       cur_cmd, cur_cmd_d;
    logic [7:0] wait_cnt, wait_cnt_d;
    logic       ref_done;

    function automatic logic [7:0] wait_load(cmd_t c);
        logic [7:0] val;
        val = 8'd0;
        case (c)
            CMD_ACT: val = 8'(T_RCD - 1);
            CMD_COL: val = 8'(T_CCD - 1);
            CMD_REF: val = 8'(T_RFC - 1);
            CMD_PRE: val = 8'(T_RP - 1);
            default: val = 8'd0;
        endcase
        return val;
    endfunction

    always_comb begin
        state_d    = state;
        cur_cmd_d  = cur_cmd;
        wait_cnt_d = wait_cnt;
        case (state)
            ST_IDLE: begin
                if (cmd_req) begin
                    cur_cmd_d = cmd_t'(cmd);
                    state_d   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                wait_cnt_d = wait_load(cur_cmd);
                state_d    = ST_WAIT;
            end
            ST_WAIT: begin
                if (wait_cnt == 8'd0) begin
                    state_d = ST_HOLD;
                end else begin
                    wait_cnt_d = wait_cnt - 8'd1;
                end
            end
            ST_HOLD: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next-state values so each one lines up
    // with the cycle its state occupies, without any input-to-output path.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= ST_IDLE;
            cur_cmd        <= CMD_ACT;
            wait_cnt       <= 8'd0;
            dram_cmd_valid <= 1'b0;
            dram_cmd       <= 2'b00;
            cmd_ack        <= 1'b0;
            busy           <= 1'b0;
        end else begin
            state          <= state_d;
            cur_cmd        <= cur_cmd_d;
            wait_cnt       <= wait_cnt_d;
            dram_cmd_valid <= (state_d == ST_ISSUE);
            dram_cmd       <= (state_d == ST_ISSUE) ? cur_cmd_d : 2'b00;
            cmd_ack        <= (state_d == ST_WAIT) && (wait_cnt_d == 8'd0);
            busy           <= (state_d != ST_IDLE);
        end
    end

    assign ref_done = cmd_ack && (cur_cmd == CMD_REF);

    dram_refresh_timer #(
        .T_REFI(T_REFI)
    ) u_refresh (
        .clk            (clk),
        .rst            (rst),
        .ref_done       (ref_done),
        .refresh_flag   (refresh_flag),
        .refresh_overdue(refresh_overdue)
    );

endmodule
